vcm_i2c_wr: RTL and testbench
=============================

VCM_I2C_WR -- requirements
Module: vcm_i2c_wr

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning CLK cycles per SCL quarter-period (50 MHz -> 100 kHz SCL); legal range 2..1023.
REQ-002 SHALL have parameter SLAVE_ADDR, default 8'h18, meaning the 8-bit write address byte sent first (VCM driver 7-bit 0x0C, R/W=0).
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port VCM_DATA  input  16  lens position word from the autofocus controller, format {2'b00, step[9:0], 4'b1111}.
REQ-006 SHALL have port FORCE  input  1  single-cycle request to resend the last word even if unchanged.
REQ-007 SHALL have port I2C_SCL  output  1  push-pull serial clock.
REQ-008 SHALL have port I2C_SDA  inout  1  open-drain data; driven 0 or released to Z, never driven 1.
REQ-009 SHALL have port BUSY  output  1  high while a transaction is in progress.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse at the end of every transaction.
REQ-011 SHALL have port ACK_ERR  output  1  NACK status of the most recent transaction.
REQ-012 SHALL have port SENT_DATA  output  16  last word acknowledged by the slave.

Function
REQ-013 SHALL use states IDLE, START, BITS, ACK, STOP.
REQ-014 SHALL hold the quarter-tick counter at 0 in IDLE; outside IDLE it SHALL count 0..CLK_DIV-1 and assert tick on CLK_DIV-1.
REQ-015 SHALL start a transaction from IDLE when VCM_DATA != SENT_DATA or FORCE=1, latch VCM_DATA into a shadow register on that cycle, and assert BUSY on the next cycle.
REQ-016 SHALL ignore VCM_DATA changes and FORCE pulses while BUSY; any change SHALL be re-evaluated in the first IDLE cycle after DONE.
REQ-017 SHALL advance one phase (0..3) per tick; each bit and each START/STOP slot SHALL take exactly 4 ticks.
REQ-018 SHALL drive START as: phases 0-1 SCL=1, SDA released; phase 2 SDA=0; phase 3 SCL=0.
REQ-019 SHALL drive each data bit in BITS as: phase 0 SCL=0, SDA set; phases 1-2 SCL=1; phase 3 SCL=0. Bits SHALL go MSB first.
REQ-020 SHALL send three bytes in order: SLAVE_ADDR, shadow[15:8], shadow[7:0]; each byte SHALL be followed by one ACK slot.
REQ-021 SHALL release SDA during ACK and sample it at the end of phase 2; 0 = ACK, 1 = NACK.
REQ-022 SHALL on NACK go directly to STOP, skipping the remaining bytes.
REQ-023 SHALL drive STOP as: phase 0 SCL=0, SDA=0; phase 1 SCL=1; phase 2 SDA released; phase 3 idle-high; then return to IDLE.
REQ-024 SHALL make a full successful transaction 116 ticks long (4 START + 27 bits x 4 + 4 STOP), i.e. 14500 CLK cycles at CLK_DIV=125.
REQ-025 SHALL pulse DONE and deassert BUSY in the cycle of the final STOP tick.
REQ-026 SHALL, on DONE, set ACK_ERR=0 and SENT_DATA=shadow if all three ACKs were received; otherwise ACK_ERR=1 and SENT_DATA unchanged.
REQ-027 SHALL retry automatically after a NACK, because SENT_DATA still differs from VCM_DATA (REQ-015).
REQ-028 SHALL hold I2C_SCL=1 and SDA released in IDLE.

Reset
REQ-029 SHALL, when RESET_n=0 at a clock edge, enter IDLE and set: tick counter=0, I2C_SCL=1, SDA released, BUSY=0, DONE=0, ACK_ERR=0, SENT_DATA=16'hFFFF.
REQ-030 SHALL abandon any transfer on reset mid-transaction without generating STOP; the bus SHALL show SCL=1 and SDA released from the next cycle.
REQ-031 SHALL, because 16'hFFFF cannot match any legal VCM_DATA, transmit the current VCM_DATA in the first IDLE cycle after reset.

Verification
REQ-032 SHALL verify: reset release with VCM_DATA=16'h123F and ACKing slave model -> bytes 18,12,3F on the bus; DONE after 14500 cycles; SENT_DATA=123F; ACK_ERR=0.
REQ-033 SHALL verify: slave NACKs the address byte -> STOP right after the first ACK slot; ACK_ERR=1; SENT_DATA unchanged; new START after the next IDLE cycle.
REQ-034 SHALL verify: VCM_DATA changes 123F->200F->300F while BUSY -> exactly one follow-up transaction, carrying 300F.
REQ-035 SHALL verify: FORCE pulse with VCM_DATA==SENT_DATA=123F -> one resend of 123F; FORCE while BUSY -> no extra transaction.
REQ-036 SHALL verify: RESET_n low during the second data bit -> next cycle SCL=1, SDA=Z, BUSY=0; after release, a fresh full transaction.
REQ-037 SHALL verify: CLK_DIV=2 -> protocol checker sees SDA change only while SCL=0, except START and STOP edges.

Source files
------------

// File: rtl/vcm_i2c_wr.sv
// -----------------------------------------------------------------------------
// vcm_i2c_wr
// Write-only I2C master that pushes a 16-bit lens position word to a VCM
// driver. Whenever VCM_DATA differs from the last acknowledged word (or FORCE
// is pulsed) it sends: START, SLAVE_ADDR, data[15:8], data[7:0], STOP. Each
// START/bit/ACK/STOP slot is four quarter-periods of CLK_DIV clocks.
//
// Ports
//   CLK        in   sole clock, rising edge
//   RESET_n    in   synchronous active-low reset
//   VCM_DATA   in   16-bit position word {2'b00, step[9:0], 4'b1111}
//   FORCE      in   single-cycle resend request
//   I2C_SCL    out  push-pull serial clock
//   I2C_SDA    io   open-drain data (driven 0 or released)
//   BUSY       out  transaction in progress
//   DONE       out  one-cycle pulse at end of each transaction
//   ACK_ERR    out  1 if the last transaction saw a NACK
//   SENT_DATA  out  last word acknowledged by the slave
// -----------------------------------------------------------------------------
module vcm_i2c_wr #(
  parameter int         CLK_DIV    = 125,
  parameter logic [7:0] SLAVE_ADDR = 8'h18
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [15:0] VCM_DATA,
  input  logic        FORCE,
  output logic        I2C_SCL,
  inout  wire         I2C_SDA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ACK_ERR,
  output logic [15:0] SENT_DATA
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BITS  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

  logic [2:0]  r_state;
  logic [9:0]  r_qcnt;
  logic [1:0]  r_phase;
  logic [2:0]  r_bit;
  logic [1:0]  r_byte;
  logic [15:0] r_shadow;
  logic        r_nack;
  logic        r_scl;
  logic        r_sda_low;
  logic        r_busy;
  logic        r_done;
  logic        r_ack_err;
  logic [15:0] r_sent;

  logic        w_tick;
  logic        w_start_req;
  logic        w_last_tick;
  logic [2:0]  w_state_nxt;
  logic [1:0]  w_phase_nxt;
  logic [2:0]  w_bit_nxt;
  logic [1:0]  w_byte_nxt;
  logic [7:0]  w_cur_byte;
  logic        w_bit_val;
  logic        w_scl_nxt;
  logic        w_sda_low_nxt;

  assign w_tick      = (r_state != S_IDLE) && (r_qcnt == QMAX);
  assign w_start_req = (r_state == S_IDLE) && ((VCM_DATA != r_sent) || FORCE);
  assign w_last_tick = w_tick && (r_state == S_STOP) && (r_phase == 2'd3);

  // Next FSM position: phase advances per tick, slot changes after phase 3.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    if (w_start_req) begin
      w_state_nxt = S_START;
      w_phase_nxt = 2'd0;
      w_bit_nxt   = 3'd7;
      w_byte_nxt  = 2'd0;
    end else if (w_tick) begin
      w_phase_nxt = r_phase + 2'd1;
      if (r_phase == 2'd3) begin
        case (r_state)
          S_START: w_state_nxt = S_BITS;
          S_BITS: begin
            if (r_bit == 3'd0) begin
              w_state_nxt = S_ACK;
            end else begin
              w_bit_nxt = r_bit - 3'd1;
            end
          end
          S_ACK: begin
            // A NACK skips straight to STOP; otherwise stop after byte 2.
            if (r_nack || (r_byte == 2'd2)) begin
              w_state_nxt = S_STOP;
            end else begin
              w_state_nxt = S_BITS;
              w_byte_nxt  = r_byte + 2'd1;
              w_bit_nxt   = 3'd7;
            end
          end
          S_STOP:  w_state_nxt = S_IDLE;
          default: w_state_nxt = S_IDLE;
        endcase
      end else begin
        w_state_nxt = r_state;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Byte being shifted out in the upcoming slot.
  always_comb begin
    case (w_byte_nxt)
      2'd0:    w_cur_byte = SLAVE_ADDR;
      2'd1:    w_cur_byte = r_shadow[15:8];
      default: w_cur_byte = r_shadow[7:0];
    endcase
  end

  assign w_bit_val = w_cur_byte[w_bit_nxt];

  // Bus levels decoded from the upcoming state so the registered pins line
  // up with the FSM without a one-cycle lag.
  always_comb begin
    w_scl_nxt     = 1'b1;
    w_sda_low_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_scl_nxt     = 1'b1;
        w_sda_low_nxt = 1'b0;
      end
      S_START: begin
        w_scl_nxt     = (w_phase_nxt != 2'd3);
        w_sda_low_nxt = (w_phase_nxt >= 2'd2);
      end
      S_BITS: begin
        w_scl_nxt     = (w_phase_nxt == 2'd1) || (w_phase_nxt == 2'd2);
        w_sda_low_nxt = ~w_bit_val;
      end
      S_ACK: begin
        w_scl_nxt     = (w_phase_nxt == 2'd1) || (w_phase_nxt == 2'd2);
        w_sda_low_nxt = 1'b0;
      end
      S_STOP: begin
        w_scl_nxt     = (w_phase_nxt != 2'd0);
        w_sda_low_nxt = (w_phase_nxt <= 2'd1);
      end
      default: begin
        w_scl_nxt     = 1'b1;
        w_sda_low_nxt = 1'b0;
      end
    endcase
  end

  // State, counters, bus pins and status registers.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_state   <= S_IDLE;
      r_qcnt    <= 10'd0;
      r_phase   <= 2'd0;
      r_bit     <= 3'd7;
      r_byte    <= 2'd0;
      r_shadow  <= 16'h0000;
      r_nack    <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_sent    <= 16'hFFFF;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_bit     <= w_bit_nxt;
      r_byte    <= w_byte_nxt;
      r_scl     <= w_scl_nxt;
      r_sda_low <= w_sda_low_nxt;
      r_done    <= w_last_tick;

      if ((r_state == S_IDLE) || w_tick) begin
        r_qcnt <= 10'd0;
      end else begin
        r_qcnt <= r_qcnt + 10'd1;
      end

      if (w_start_req) begin
        r_shadow <= VCM_DATA;
        r_nack   <= 1'b0;
        r_busy   <= 1'b1;
      end else if (w_tick && (r_state == S_ACK) && (r_phase == 2'd2)) begin
        // Released line reads 1 through the pull-up: that is a NACK.
        r_nack <= (I2C_SDA != 1'b0);
      end else if (w_last_tick) begin
        r_busy <= 1'b0;
        if (r_nack) begin
          r_ack_err <= 1'b1;
        end else begin
          r_ack_err <= 1'b0;
          r_sent    <= r_shadow;
        end
      end else begin
        r_busy <= r_busy;
      end
    end
  end

  assign I2C_SCL   = r_scl;
  assign I2C_SDA   = r_sda_low ? 1'b0 : 1'bz;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ACK_ERR   = r_ack_err;
  assign SENT_DATA = r_sent;

endmodule

// File: tb/tb_vcm_i2c_wr.sv
// -----------------------------------------------------------------------------
// tb_vcm_i2c_wr
// Directed bench for vcm_i2c_wr. Instance 0 uses the default divider for the
// full-length timing case; instance 1 uses CLK_DIV=2 for protocol scenarios.
// A small slave model per bus captures bytes, ACKs (or NACKs the address on
// request) and flags SDA edges during SCL high that are not a legal
// START/STOP.
// -----------------------------------------------------------------------------
module tb_vcm_i2c_wr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n = 2'b00;
  logic [1:0]  frc   = 2'b00;
  logic [15:0] vcm0  = 16'h123F;
  logic [15:0] vcm1  = 16'h123F;
  logic [1:0]  nack_addr = 2'b00;

  wire [1:0]  scl;
  wire [1:0]  busy;
  wire [1:0]  done;
  wire [1:0]  ack_err;
  wire [15:0] sent0;
  wire [15:0] sent1;
  wire        sda0;
  wire        sda1;
  wire [1:0]  sda_obs;

  logic [1:0] drv = 2'b00;

  pullup (sda0);
  pullup (sda1);
  assign sda0 = drv[0] ? 1'b0 : 1'bz;
  assign sda1 = drv[1] ? 1'b0 : 1'bz;
  assign sda_obs = {sda1, sda0};

  vcm_i2c_wr #(.CLK_DIV(125), .SLAVE_ADDR(8'h18)) dut0 (
    .CLK(clk), .RESET_n(rst_n[0]), .VCM_DATA(vcm0), .FORCE(frc[0]),
    .I2C_SCL(scl[0]), .I2C_SDA(sda0), .BUSY(busy[0]), .DONE(done[0]),
    .ACK_ERR(ack_err[0]), .SENT_DATA(sent0)
  );

  vcm_i2c_wr #(.CLK_DIV(2), .SLAVE_ADDR(8'h18)) dut1 (
    .CLK(clk), .RESET_n(rst_n[1]), .VCM_DATA(vcm1), .FORCE(frc[1]),
    .I2C_SCL(scl[1]), .I2C_SDA(sda1), .BUSY(busy[1]), .DONE(done[1]),
    .ACK_ERR(ack_err[1]), .SENT_DATA(sent1)
  );

  // Slave model state
  logic [1:0] p_scl  = 2'b11;
  logic [1:0] p_sda  = 2'b11;
  logic [1:0] in_txn = 2'b00;
  logic [7:0] sh [2];
  logic [7:0] cap [2][3];
  int bitcnt [2];
  int byteidx [2];
  int n_start [2];
  int n_stop [2];
  int proto_err [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      bitcnt[k] = 0; byteidx[k] = 0; n_start[k] = 0; n_stop[k] = 0;
      proto_err[k] = 0; sh[k] = 8'h00;
      for (int b = 0; b < 3; b++) cap[k][b] = 8'h00;
    end
  end

  // Slave: START/STOP detection, byte capture, ACK drive, protocol check.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      p_scl[i] <= scl[i];
      p_sda[i] <= sda_obs[i];
      if (!rst_n[i]) begin
        in_txn[i] <= 1'b0;
        drv[i]    <= 1'b0;
        bitcnt[i] <= 0;
      end else if (p_scl[i] && scl[i] && p_sda[i] && !sda_obs[i]) begin
        if (in_txn[i]) proto_err[i] <= proto_err[i] + 1;
        in_txn[i]  <= 1'b1;
        n_start[i] <= n_start[i] + 1;
        bitcnt[i]  <= 0;
        byteidx[i] <= 0;
        drv[i]     <= 1'b0;
      end else if (p_scl[i] && scl[i] && !p_sda[i] && sda_obs[i]) begin
        if (!in_txn[i] || bitcnt[i] != 1) proto_err[i] <= proto_err[i] + 1;
        in_txn[i] <= 1'b0;
        n_stop[i] <= n_stop[i] + 1;
        drv[i]    <= 1'b0;
      end else if (in_txn[i]) begin
        if (!p_scl[i] && scl[i]) begin
          bitcnt[i] <= bitcnt[i] + 1;
          if (bitcnt[i] < 8) sh[i] <= {sh[i][6:0], sda_obs[i]};
          if (bitcnt[i] == 7 && byteidx[i] < 3) cap[i][byteidx[i]] <= {sh[i][6:0], sda_obs[i]};
        end else if (p_scl[i] && !scl[i]) begin
          if (bitcnt[i] == 8) begin
            drv[i] <= !(nack_addr[i] && byteidx[i] == 0);
          end else if (bitcnt[i] == 9) begin
            drv[i]     <= 1'b0;
            bitcnt[i]  <= 0;
            byteidx[i] <= byteidx[i] + 1;
          end
        end
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_busy(input int i, input int limit, input string tag);
    int n;
    n = 0;
    while (busy[i] !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    chk(tag, {31'd0, busy[i]}, 32'd1);
  endtask

  task automatic wait_done(input int i, input int limit, input string tag, output int n);
    n = 0;
    while (done[i] !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    chk(tag, {31'd0, done[i]}, 32'd1);
  endtask

  task automatic chk_bytes(input int i, input string tag, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2);
    chk({tag, "_b0"}, {24'd0, cap[i][0]}, {24'd0, b0});
    chk({tag, "_b1"}, {24'd0, cap[i][1]}, {24'd0, b1});
    chk({tag, "_b2"}, {24'd0, cap[i][2]}, {24'd0, b2});
  endtask

  initial begin
    int n;
    int s;
    step(3);

    // Reset state
    chk("rst_busy",   {31'd0, busy[0]},    32'd0);
    chk("rst_done",   {31'd0, done[0]},    32'd0);
    chk("rst_ackerr", {31'd0, ack_err[0]}, 32'd0);
    chk("rst_sent",   {16'd0, sent0},      32'h0000_FFFF);
    chk("rst_scl",    {31'd0, scl[0]},     32'd1);
    chk("rst_sda",    {31'd0, sda0},       32'd1);

    // Full transaction at default divider after reset release
    rst_n[0] = 1'b1;
    wait_busy(0, 10, "t1_busy");
    wait_done(0, 20000, "t1_done", n);
    chk("t1_cycles", n, 32'd14500);
    chk("t1_sent",   {16'd0, sent0}, 32'h0000_123F);
    chk("t1_ackerr", {31'd0, ack_err[0]}, 32'd0);
    chk("t1_busy_lo", {31'd0, busy[0]}, 32'd0);
    chk_bytes(0, "t1", 8'h18, 8'h12, 8'h3F);
    chk("t1_nbytes", byteidx[0], 32'd3);

    // Fast instance: first transaction
    rst_n[1] = 1'b1;
    wait_busy(1, 10, "a_busy");
    wait_done(1, 1000, "a_done", n);
    chk("a_cycles", n, 32'd232);
    chk("a_sent", {16'd0, sent1}, 32'h0000_123F);
    chk_bytes(1, "a", 8'h18, 8'h12, 8'h3F);

    // Address NACK: short transaction, error flagged, automatic retry
    nack_addr[1] = 1'b1;
    vcm1 = 16'h200F;
    wait_busy(1, 10, "nack_busy");
    s = n_stop[1];
    wait_done(1, 1000, "nack_done", n);
    chk("nack_cycles", n, 32'd88);
    chk("nack_ackerr", {31'd0, ack_err[1]}, 32'd1);
    chk("nack_sent",   {16'd0, sent1}, 32'h0000_123F);
    chk("nack_nbytes", byteidx[1], 32'd1);
    chk("nack_stop",   n_stop[1] - s, 32'd1);
    nack_addr[1] = 1'b0;
    step(1);
    chk("retry_busy", {31'd0, busy[1]}, 32'd1);
    chk("retry_done_lo", {31'd0, done[1]}, 32'd0);
    wait_done(1, 1000, "retry_done", n);
    chk("retry_cycles", n, 32'd232);
    chk("retry_sent",   {16'd0, sent1}, 32'h0000_200F);
    chk("retry_ackerr", {31'd0, ack_err[1]}, 32'd0);
    chk_bytes(1, "retry", 8'h18, 8'h20, 8'h0F);

    // Changes while busy collapse into one follow-up carrying the latest word
    s = n_start[1];
    vcm1 = 16'h123F;
    step(1);
    chk("chg_busy", {31'd0, busy[1]}, 32'd1);
    step(20);
    vcm1 = 16'h200F;
    step(20);
    vcm1 = 16'h300F;
    wait_done(1, 1000, "chg_done1", n);
    chk("chg_sent1", {16'd0, sent1}, 32'h0000_123F);
    step(1);
    chk("chg_follow_busy", {31'd0, busy[1]}, 32'd1);
    wait_done(1, 1000, "chg_done2", n);
    chk("chg_sent2", {16'd0, sent1}, 32'h0000_300F);
    chk_bytes(1, "chg", 8'h18, 8'h30, 8'h0F);
    step(300);
    chk("chg_idle", {31'd0, busy[1]}, 32'd0);
    chk("chg_starts", n_start[1] - s, 32'd2);

    // FORCE resend; FORCE while busy is dropped
    s = n_start[1];
    frc[1] = 1'b1;
    step(1);
    frc[1] = 1'b0;
    chk("frc_busy", {31'd0, busy[1]}, 32'd1);
    step(30);
    frc[1] = 1'b1;
    step(1);
    frc[1] = 1'b0;
    wait_done(1, 1000, "frc_done", n);
    chk("frc_sent", {16'd0, sent1}, 32'h0000_300F);
    chk("frc_ackerr", {31'd0, ack_err[1]}, 32'd0);
    chk_bytes(1, "frc", 8'h18, 8'h30, 8'h0F);
    step(300);
    chk("frc_idle", {31'd0, busy[1]}, 32'd0);
    chk("frc_starts", n_start[1] - s, 32'd1);

    // Reset during the second data bit of the address byte
    vcm1 = 16'h123F;
    step(1);
    chk("mid_busy", {31'd0, busy[1]}, 32'd1);
    step(17);
    rst_n[1] = 1'b0;
    step(1);
    chk("mid_scl",  {31'd0, scl[1]},  32'd1);
    chk("mid_sda",  {31'd0, sda1},    32'd1);
    chk("mid_busy_lo", {31'd0, busy[1]}, 32'd0);
    chk("mid_sent", {16'd0, sent1},   32'h0000_FFFF);
    step(2);
    rst_n[1] = 1'b1;
    wait_busy(1, 10, "mid_rebusy");
    wait_done(1, 1000, "mid_done", n);
    chk("mid_cycles", n, 32'd232);
    chk("mid_sent2", {16'd0, sent1}, 32'h0000_123F);
    chk_bytes(1, "mid", 8'h18, 8'h12, 8'h3F);

    // SDA must only move while SCL is low, apart from START/STOP
    chk("proto0", proto_err[0], 32'd0);
    chk("proto1", proto_err[1], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
